// File: rtl/rv32_debug_uart_if.sv
// Writeback snoop bundle between the rv32 core's mem/writeback stage and the debug UART.
// The core side drives (master); the UART only observes (slave).
interface rv32_debug_uart_if;
    logic [4:0]  wb_rd_in;
    logic        wb_rd_writeback_in;
    logic [31:0] wb_rd_value_in;

    modport master (
        output wb_rd_in,
        output wb_rd_writeback_in,
        output wb_rd_value_in
    );

    modport slave (
        input wb_rd_in,
        input wb_rd_writeback_in,
        input wb_rd_value_in
    );
endinterface

// File: rtl/rv32_debug_uart.sv
// Debug UART transmitter: captures the low byte of every writeback to DEBUG_REG into a
// small FIFO and serialises it 8N1, LSB first, on a flop-driven TX line.
module rv32_debug_uart #(
    parameter int unsigned CLK_DIV    = 104,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DEBUG_REG  = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    rv32_debug_uart_if.slave        wb,
    output logic                    tx_out,
    output logic                    busy_out,
    output logic                    overflow_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_overflow;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_baud_end;
    logic       w_fifo_empty;
    logic       w_fifo_full;
    logic       w_capture;
    logic       w_pop;
    logic       w_push;
    logic [7:0] w_head;
    logic       w_unused_hi;

    assign w_baud_end   = (r_baud == BAUD_LAST);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_unused_hi  = ^wb.wb_rd_value_in[31:8];

    assign w_capture = wb.wb_rd_writeback_in && (wb.wb_rd_in == 5'(DEBUG_REG));

    // Pops happen only from IDLE or at the last cycle of a stop bit.
    assign w_pop  = !w_fifo_empty &&
                    ((r_state == StIdle) || ((r_state == StStop) && w_baud_end));
    assign w_push = w_capture && (!w_fifo_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wb.wb_rd_value_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line is a pure flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift   <= w_head;
                        r_bit_idx <= '0;
                        r_baud    <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= StStart;
                    end
                end
                StStart: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= StData;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                StData: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                StStop: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_fifo_empty) begin
                            r_shift   <= w_head;
                            r_bit_idx <= '0;
                            r_tx      <= 1'b0;
                            r_state   <= StStart;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= StIdle;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign tx_out       = r_tx;
    assign busy_out     = (r_state != StIdle) || !w_fifo_empty;
    assign overflow_out = r_overflow;

endmodule

// File: tb/tb_rv32_debug_uart.sv
// Directed bench for rv32_debug_uart with CLK_DIV=4, FIFO_DEPTH=4, DEBUG_REG=31;
// a cycle-aligned receiver decodes each frame by sampling the middle of every bit.
module tb_rv32_debug_uart;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, busy, ovf;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] rb;
    int         rw;
    logic [7:0] v;

    rv32_debug_uart_if wb_if ();

    rv32_debug_uart #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (4),
        .DEBUG_REG  (31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb           (wb_if.slave),
        .tx_out       (tx),
        .busy_out     (busy),
        .overflow_out (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] val, input logic we);
        wb_if.wb_rd_in           = rd;
        wb_if.wb_rd_value_in     = val;
        wb_if.wb_rd_writeback_in = we;
    endtask

    // phase = cycles already elapsed in the current start bit when called with tx low.
    task automatic rx_frame(input int phase, input int max_wait,
                            output logic [7:0] b, output int waited);
        int t;
        logic [9:0] bits;
        waited = 0;
        b = '0;
        while (tx !== 1'b0 && waited < max_wait) begin
            tick();
            waited++;
        end
        if (tx !== 1'b0) begin
            chk("rx_start_timeout", 32'(tx), 32'd0);
            return;
        end
        t = (waited == 0) ? phase : 0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            int target;
            target = DIV / 2 + DIV * k;
            if (target >= t) begin
                while (t < target) begin
                    tick();
                    t++;
                end
                bits[k] = tx;
            end
        end
        while (t < 10 * DIV) begin
            tick();
            t++;
        end
        chk("rx_start_bit", 32'(bits[0]), 32'd0);
        chk("rx_stop_bit", 32'(bits[9]), 32'd1);
        b = bits[8:1];
    endtask

    initial begin
        drive(5'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        tick();

        // Single 0xA5 frame, exact start latency and idle after stop.
        drive(5'd31, 32'h0000_00A5, 1'b1);
        tick();
        drive(5'd0, 32'd0, 1'b0);
        chk("a_tx_before_start", 32'(tx), 32'd1);
        chk("a_busy_queued", 32'(busy), 32'd1);
        rx_frame(0, 10, rb, rw);
        chk("a_latency", 32'(rw), 32'd1);
        chk("a_byte", 32'(rb), 32'hA5);
        chk("a_busy_after", 32'(busy), 32'd0);
        chk("a_tx_after", 32'(tx), 32'd1);
        chk("a_ovf", 32'(ovf), 32'd0);

        // Non-debug register and invalid writeback are ignored.
        drive(5'd30, 32'h0000_00FF, 1'b1);
        tick();
        chk("b_x30_quiet", 32'({tx, busy}), 32'b10);
        drive(5'd31, 32'h0000_005A, 1'b0);
        tick();
        drive(5'd0, 32'd0, 1'b0);
        chk("b_nowb_quiet", 32'({tx, busy}), 32'b10);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("b_idle_line", 32'({tx, busy}), 32'b10);
        end

        // Three consecutive writes: back-to-back frames with no gap.
        drive(5'd31, 32'h41, 1'b1);
        tick();
        drive(5'd31, 32'h42, 1'b1);
        tick();
        drive(5'd31, 32'h43, 1'b1);
        tick();
        drive(5'd0, 32'd0, 1'b0);
        rx_frame(1, 0, rb, rw);
        chk("c_byte0", 32'(rb), 32'h41);
        rx_frame(0, 0, rb, rw);
        chk("c_byte1", 32'(rb), 32'h42);
        rx_frame(0, 0, rb, rw);
        chk("c_byte2", 32'(rb), 32'h43);
        chk("c_busy_after", 32'(busy), 32'd0);
        chk("c_ovf", 32'(ovf), 32'd0);

        // Six consecutive writes into a depth-4 FIFO: 0x15 is dropped.
        for (int i = 0; i < 6; i++) begin
            drive(5'd31, 32'(8'h10 + 8'(i)), 1'b1);
            tick();
            chk("d_ovf_step", 32'(ovf), 32'(i == 5));
        end
        drive(5'd0, 32'd0, 1'b0);
        rx_frame(4, 0, rb, rw);
        chk("d_byte_10", 32'(rb), 32'h10);
        for (int i = 1; i < 5; i++) begin
            rx_frame(0, 0, rb, rw);
            chk("d_byte_n", 32'(rb), 32'(8'h10 + 8'(i)));
        end
        chk("d_busy_after", 32'(busy), 32'd0);
        chk("d_ovf_sticky", 32'(ovf), 32'd1);
        tick();
        chk("d_no_extra_frame", 32'(tx), 32'd1);

        // Reset clears sticky overflow.
        reset = 1'b1;
        tick();
        chk("e_reset_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;

        // Reset mid-DATA of 0x55 with two bytes queued.
        drive(5'd31, 32'h55, 1'b1);
        tick();
        drive(5'd31, 32'h66, 1'b1);
        tick();
        drive(5'd31, 32'h77, 1'b1);
        tick();
        drive(5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("e_data_bit1", 32'(tx), 32'd0);
        chk("e_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("e_async_tx", 32'(tx), 32'd1);
        chk("e_async_busy", 32'(busy), 32'd0);
        chk("e_async_ovf", 32'(ovf), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("e_quiet_after_reset", 32'({tx, busy}), 32'b10);
        end
        drive(5'd31, 32'h3C, 1'b1);
        tick();
        drive(5'd0, 32'd0, 1'b0);
        rx_frame(0, 10, rb, rw);
        chk("e_resume_latency", 32'(rw), 32'd1);
        chk("e_resume_byte", 32'(rb), 32'h3C);

        // Nine spaced bytes: pointers wrap twice.
        for (int i = 0; i < 9; i++) begin
            v = 8'h3A + 8'(i) * 8'h1D;
            drive(5'd31, {24'hABCDEF, v}, 1'b1);
            tick();
            drive(5'd0, 32'd0, 1'b0);
            rx_frame(0, 10, rb, rw);
            chk("f_wrap_byte", 32'(rb), 32'(v));
            chk("f_wrap_latency", 32'(rw), 32'd1);
        end
        chk("f_busy_end", 32'(busy), 32'd0);
        chk("f_ovf_end", 32'(ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
